// File: rtl/demux.sv
// Receive end of the 2:1 time-multiplexed nibble link.
// Splits the interleaved word stream (lane 1, lane 0, lane 1, ...) back into
// two parallel lanes, pulsing valid_out once per completed pair. A sync marker
// on a word forces it to be treated as lane 1; a marker arriving while a lane 0
// word is expected sets the sticky sync_err flag.
module demux #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             sync_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic             valid_out,
  output logic             sync_err,
  output logic [CNT_W-1:0] pair_count
);

  // Lane phase: which lane the next accepted word belongs to.
  localparam logic [0:0] EXP1 = 1'b0;
  localparam logic [0:0] EXP0 = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic [WIDTH-1:0] data_0_q, data_0_d;
  logic [WIDTH-1:0] data_1_q, data_1_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state logic: phase tracking, pair assembly, error and counter update.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    hold_d   = hold_q;
    data_0_d = data_0_q;
    data_1_d = data_1_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;

    // Clear first so a misalignment on the same edge overrides it.
    if (err_clr) begin
      err_d = 1'b0;
    end

    if (valid_in) begin
      if (state_q == EXP1) begin
        // Lane 1 word: park it until its lane 0 partner arrives.
        hold_d  = data_in;
        state_d = EXP0;
      end else if (sync_in) begin
        // Marker where lane 0 was expected: drop the parked word and
        // restart the pair with this one as lane 1.
        hold_d = data_in;
        err_d  = 1'b1;
      end else begin
        // Lane 0 word completes the pair.
        data_1_d = hold_q;
        data_0_d = data_in;
        valid_d  = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = EXP1;
      end
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    if (reset) begin
      state_q  <= EXP1;
      hold_q   <= '0;
      data_0_q <= '0;
      data_1_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      data_0_q <= data_0_d;
      data_1_q <= data_1_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_0     = data_0_q;
  assign data_1     = data_1_q;
  assign valid_out  = valid_q;
  assign sync_err   = err_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// pending-word model of the link.
module tb_demux;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic       sync_in;
  logic [3:0] data_in;
  logic       err_clr;

  logic [3:0] data_0, data_1;
  logic       valid_out, sync_err;
  logic [7:0] pair_count;

  logic [3:0] s_data_0, s_data_1;
  logic       s_valid_out, s_sync_err;
  logic [1:0] s_pair_count;

  int n_vec  = 0;
  int n_fail = 0;

  demux #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sync_in(sync_in),
    .data_in(data_in), .err_clr(err_clr), .data_0(data_0), .data_1(data_1),
    .valid_out(valid_out), .sync_err(sync_err), .pair_count(pair_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  demux #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sync_in(sync_in),
    .data_in(data_in), .err_clr(err_clr), .data_0(s_data_0), .data_1(s_data_1),
    .valid_out(s_valid_out), .sync_err(s_sync_err), .pair_count(s_pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is either waiting for its partner or not.
  logic       m_have;
  logic [3:0] m_hold, m_d0, m_d1;
  logic       m_vo, m_err;
  int         m_pairs;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_have = 1'b0; m_hold = 4'h0; m_d0 = 4'h0; m_d1 = 4'h0;
      m_vo = 1'b0; m_err = 1'b0; m_pairs = 0;
    end else begin
      m_vo = 1'b0;
      if (valid_in && m_have && sync_in) begin
        m_hold = data_in;
        m_err  = 1'b1;
      end else begin
        if (err_clr) m_err = 1'b0;
        if (valid_in) begin
          if (!m_have) begin
            m_hold = data_in;
            m_have = 1'b1;
          end else begin
            m_d1 = m_hold;
            m_d0 = data_in;
            m_vo = 1'b1;
            m_pairs++;
            m_have = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("data_0", 32'(data_0), 32'(m_d0));
    check("data_1", 32'(data_1), 32'(m_d1));
    check("valid_out", 32'(valid_out), 32'(m_vo));
    check("sync_err", 32'(sync_err), 32'(m_err));
    check("pair_count", 32'(pair_count), (m_pairs > 255) ? 32'd255 : 32'(m_pairs));
    check("sat_data_0", 32'(s_data_0), 32'(m_d0));
    check("sat_data_1", 32'(s_data_1), 32'(m_d1));
    check("sat_valid_out", 32'(s_valid_out), 32'(m_vo));
    check("sat_sync_err", 32'(s_sync_err), 32'(m_err));
    check("sat_pair_count", 32'(s_pair_count), (m_pairs > 3) ? 32'd3 : 32'(m_pairs));
  end

  // Drive one word for one edge; outputs of that edge are visible on return.
  task automatic word(input logic [3:0] d, input logic s);
    valid_in = 1'b1; data_in = d; sync_in = s;
    @(posedge clk); #1;
    valid_in = 1'b0; sync_in = 1'b0; data_in = $urandom_range(0, 15);
  endtask

  task automatic idle();
    valid_in = 1'b0; sync_in = $urandom_range(0, 1);
    @(posedge clk); #1;
    sync_in = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; #2; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; sync_in = 1'b0; data_in = 4'h0; err_clr = 1'b0;
    #1 reset = 1'b1;
    #20;
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_pair_count", 32'(pair_count), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: two back-to-back pairs.
    word(4'hA, 1'b0);
    word(4'h5, 1'b0);
    check("t1_d1", 32'(data_1), 32'hA);
    check("t1_d0", 32'(data_0), 32'h5);
    check("t1_vo", 32'(valid_out), 32'd1);
    check("t1_cnt", 32'(pair_count), 32'd1);
    word(4'h3, 1'b0);
    check("t1_vo_low", 32'(valid_out), 32'd0);
    word(4'hC, 1'b0);
    check("t1_d1b", 32'(data_1), 32'h3);
    check("t1_d0b", 32'(data_0), 32'hC);
    check("t1_cntb", 32'(pair_count), 32'd2);

    // 2: stall inside a pair.
    word(4'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t2_stall_vo", 32'(valid_out), 32'd0);
    end
    word(4'h2, 1'b0);
    check("t2_vo", 32'(valid_out), 32'd1);
    check("t2_d1", 32'(data_1), 32'h1);
    check("t2_d0", 32'(data_0), 32'h2);

    // 3: misalignment.
    pulse_reset();
    word(4'h7, 1'b0);
    word(4'h9, 1'b1);
    check("t3_err", 32'(sync_err), 32'd1);
    check("t3_vo", 32'(valid_out), 32'd0);
    word(4'h4, 1'b0);
    check("t3_d1", 32'(data_1), 32'h9);
    check("t3_d0", 32'(data_0), 32'h4);
    check("t3_cnt", 32'(pair_count), 32'd1);

    // 4: clear.
    err_clr = 1'b1; idle(); err_clr = 1'b0;
    check("t4_err_clr", 32'(sync_err), 32'd0);

    // 5: clear and misalignment on the same edge.
    word(4'h6, 1'b0);
    err_clr = 1'b1; word(4'h8, 1'b1); err_clr = 1'b0;
    check("t5_err_wins", 32'(sync_err), 32'd1);

    // 6: saturation of the narrow counter.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      word(4'(i), 1'b0);
      word(4'(i + 8), 1'b0);
    end
    check("t6_sat", 32'(s_pair_count), 32'd3);
    check("t6_wide", 32'(pair_count), 32'd5);

    // 7: reset in the middle of a pair.
    word(4'hB, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t7_d0", 32'(data_0), 32'd0);
    check("t7_d1", 32'(data_1), 32'd0);
    check("t7_cnt", 32'(pair_count), 32'd0);
    check("t7_err", 32'(sync_err), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    word(4'hE, 1'b0);
    word(4'hF, 1'b0);
    check("t7_d1e", 32'(data_1), 32'hE);
    check("t7_d0f", 32'(data_0), 32'hF);
    check("t7_vo", 32'(valid_out), 32'd1);

    // Randomized traffic, checked by the every-cycle compare.
    for (int i = 0; i < 600; i++) begin
      err_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      if ($urandom_range(0, 9) < 7) begin
        word(4'($urandom_range(0, 15)), ($urandom_range(0, 6) == 0));
      end else begin
        idle();
      end
    end
    err_clr = 1'b0;

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
